// File: rtl/dc_motor_pkg.sv
// Shared definitions for the DC motor bridge: state encoding, direction constants and output decode.
// The FAULT state exists only when DC_BRIDGE_FAULT_EN is defined.
package dc_motor_pkg;

  localparam logic        DIR_FWD           = 1'b1;
  localparam logic        DIR_REV           = 1'b0;
  localparam int unsigned DEAD_TIME_CYC_DEF = 1000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEAD    = 3'd1,
    ST_RUN_FWD = 3'd2,
    ST_RUN_REV = 3'd3,
`ifdef DC_BRIDGE_FAULT_EN
    ST_BRAKE   = 3'd4,
    ST_FAULT   = 3'd5
`else
    ST_BRAKE   = 3'd4
`endif
  } state_e;

  typedef struct packed {
    logic in1;
    logic in2;
    logic ena;
  } drive_t;

  // Pin levels for a state; the PWM only reaches ena in the two RUN states.
  function automatic drive_t drive_decode(input state_e st, input logic pwm);
    drive_t d;
    d = '0;
    case (st)
      ST_RUN_FWD: d = '{in1: 1'b1, in2: 1'b0, ena: pwm};
      ST_RUN_REV: d = '{in1: 1'b0, in2: 1'b1, ena: pwm};
      ST_BRAKE:   d = '{in1: 1'b1, in2: 1'b1, ena: 1'b1};
      default:    d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dc_bridge_ctrl_if.sv
// Control and pin bundle between the motor controller and the H-bridge sequencer.
// fault_n / fault are present only when DC_BRIDGE_FAULT_EN is defined.
interface dc_bridge_ctrl_if;
  logic enable;
  logic pwm_in;
  logic dir_req;
  logic brake_req;
  logic in1;
  logic in2;
  logic ena;
  logic dir_state;
  logic busy;
`ifdef DC_BRIDGE_FAULT_EN
  logic fault_n;
  logic fault;

  modport master (
    output enable, pwm_in, dir_req, brake_req, fault_n,
    input  in1, in2, ena, dir_state, busy, fault
  );
  modport slave (
    input  enable, pwm_in, dir_req, brake_req, fault_n,
    output in1, in2, ena, dir_state, busy, fault
  );
`else
  modport master (
    output enable, pwm_in, dir_req, brake_req,
    input  in1, in2, ena, dir_state, busy
  );
  modport slave (
    input  enable, pwm_in, dir_req, brake_req,
    output in1, in2, ena, dir_state, busy
  );
`endif
endinterface

// File: rtl/bridge_dead_timer.sv
// Dead-time counter: zeroed on DEAD entry, counts while DEAD is held, cleared on exit.
// done flags the last dead cycle; the count saturates instead of wrapping.
module bridge_dead_timer
  import dc_motor_pkg::*;
#(
  parameter int unsigned DEAD_TIME_CYC = DEAD_TIME_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_hold,
  output logic o_done
);

  localparam int unsigned CNT_W = $clog2(DEAD_TIME_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEAD_TIME_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_TIME_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_hold) begin
      if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_done = (r_cnt == CNT_LAST);

endmodule

// File: rtl/dc_bridge_ctrl.sv
// H-bridge sequencer: direction/brake FSM with enforced all-off dead time and registered pin decode.
// Define DC_BRIDGE_FAULT_EN to add the synchronized overcurrent input and the latching FAULT state.
module dc_bridge_ctrl
  import dc_motor_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned DEAD_TIME_CYC = DEAD_TIME_CYC_DEF
) (
  input logic             clk,
  input logic             rst,
  dc_bridge_ctrl_if.slave bus
);

  generate
    if (CLK_FREQ == 0 || DEAD_TIME_CYC < 1 || DEAD_TIME_CYC > (1 << 20)) begin : g_cfg_err
      $error("dc_bridge_ctrl: DEAD_TIME_CYC must be 1..2^20 and CLK_FREQ nonzero");
    end
  endgenerate

  state_e r_state;
  state_e w_state_nxt;
  drive_t w_drive;
  logic   w_dead_done;
  logic   w_dead_start;
  logic   w_dead_hold;

  logic   r_in1;
  logic   r_in2;
  logic   r_ena;
  logic   r_dir_state;
  logic   r_busy;

`ifdef DC_BRIDGE_FAULT_EN
  logic   r_fault_s1;
  logic   r_fault_s2;
  logic   r_fault;

  // Overcurrent pin is asynchronous to clk; idles high (no fault) out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault_s1 <= 1'b1;
      r_fault_s2 <= 1'b1;
    end else begin
      r_fault_s1 <= bus.fault_n;
      r_fault_s2 <= r_fault_s1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.enable) w_state_nxt = ST_DEAD;
      end
      ST_DEAD: begin
        if (bus.brake_req)
          w_state_nxt = ST_BRAKE;
        else if (w_dead_done)
          w_state_nxt = (bus.dir_req == DIR_FWD) ? ST_RUN_FWD : ST_RUN_REV;
      end
      ST_RUN_FWD, ST_RUN_REV: begin
        if (bus.brake_req)
          w_state_nxt = ST_BRAKE;
        else if (bus.dir_req != r_dir_state)
          w_state_nxt = ST_DEAD;
      end
      ST_BRAKE: begin
        if (!bus.brake_req) w_state_nxt = ST_DEAD;
      end
`ifdef DC_BRIDGE_FAULT_EN
      ST_FAULT: begin
        if (!bus.enable && r_fault_s2) w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    // Overrides in rising priority: coast on disable, then a latched fault beats everything.
`ifdef DC_BRIDGE_FAULT_EN
    if (!bus.enable && r_state != ST_FAULT) w_state_nxt = ST_IDLE;
    if (!r_fault_s2) w_state_nxt = ST_FAULT;
`else
    if (!bus.enable) w_state_nxt = ST_IDLE;
`endif
  end

  assign w_dead_start = (w_state_nxt == ST_DEAD) && (r_state != ST_DEAD);
  assign w_dead_hold  = (w_state_nxt == ST_DEAD) && (r_state == ST_DEAD);

  bridge_dead_timer #(
    .DEAD_TIME_CYC (DEAD_TIME_CYC)
  ) u_dead_timer (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_dead_start),
    .i_hold  (w_dead_hold),
    .o_done  (w_dead_done)
  );

  // Pins are decoded from the next state so they change on the same edge as r_state.
  assign w_drive = drive_decode(w_state_nxt, bus.pwm_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in1       <= 1'b0;
      r_in2       <= 1'b0;
      r_ena       <= 1'b0;
      r_busy      <= 1'b0;
      r_dir_state <= DIR_FWD;
    end else begin
      r_in1  <= w_drive.in1;
      r_in2  <= w_drive.in2;
      r_ena  <= w_drive.ena;
      r_busy <= (w_state_nxt == ST_DEAD);
      if (w_state_nxt == ST_RUN_FWD)      r_dir_state <= DIR_FWD;
      else if (w_state_nxt == ST_RUN_REV) r_dir_state <= DIR_REV;
    end
  end

  assign bus.in1       = r_in1;
  assign bus.in2       = r_in2;
  assign bus.ena       = r_ena;
  assign bus.busy      = r_busy;
  assign bus.dir_state = r_dir_state;

`ifdef DC_BRIDGE_FAULT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fault <= 1'b0;
    else      r_fault <= (w_state_nxt == ST_FAULT);
  end

  assign bus.fault = r_fault;
`endif

endmodule

// File: doc/dc_bridge_ctrl.md
DC_BRIDGE_CTRL -- requirements
Module: dc_bridge_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz (documentation and derived timing).
REQ-002 Parameter DEAD_TIME_CYC, default 1000, clock cycles of all-off bridge before any direction or brake exit; legal range 1..2^20.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  1 = bridge may drive; 0 = coast.
REQ-006 pwm_in  in  1  speed PWM from the DC PWM generator stage.
REQ-007 dir_req  in  1  requested direction; 1 = forward, 0 = reverse.
REQ-008 brake_req  in  1  1 = dynamic brake requested.
REQ-009 in1, in2  out  1 each  bridge direction pins, registered.
REQ-010 ena  out  1  bridge enable/PWM pin, registered.
REQ-011 dir_state  out  1  direction currently driven; valid in RUN states.
REQ-012 busy  out  1  high while in DEAD state.

Function
REQ-013 States: IDLE, DEAD, RUN_FWD, RUN_REV, BRAKE, plus FAULT when configured.
REQ-014 Output decode: IDLE/DEAD: in1=0, in2=0, ena=0; RUN_FWD: in1=1, in2=0, ena=pwm_in; RUN_REV: in1=0, in2=1, ena=pwm_in; BRAKE: in1=1, in2=1, ena=1.
REQ-015 All outputs are registered; pwm_in reaches ena exactly one clk later.
REQ-016 Priority per cycle: FAULT > enable=0 > brake_req > direction change.
REQ-017 enable=0 in any non-FAULT state -> IDLE on the next edge; the dead-time counter is cleared.
REQ-018 IDLE with enable=1 -> DEAD.
REQ-019 RUN_x with brake_req=1 -> BRAKE.
REQ-020 RUN_x with dir_req differing from dir_state -> DEAD.
REQ-021 BRAKE with brake_req=0 -> DEAD.
REQ-022 DEAD -> BRAKE if brake_req=1; the dead time is honoured only on exit from BRAKE or direction change.
REQ-023 DEAD: counter loads 0 on entry and increments each cycle. When it reaches DEAD_TIME_CYC-1, the next state is RUN_FWD or RUN_REV per dir_req sampled on that cycle.
REQ-024 A dir_req toggle during DEAD does not restart the counter; the final sample wins.
REQ-025 in1=in2=1 with ena toggling never occurs; no transition between RUN_FWD and RUN_REV bypasses DEAD.
REQ-026 Counter width is $clog2(DEAD_TIME_CYC+1); the counter saturates and never wraps.

Reset
REQ-027 While rst=0: state=IDLE, counter=0, in1=0, in2=0, ena=0, dir_state=1, busy=0.
REQ-028 Reset deassertion mid-operation restarts from IDLE; the full dead time applies before any RUN.

Configuration
REQ-029 Macro DC_BRIDGE_FAULT_EN adds input fault_n (active-low overcurrent) and output fault.
- fault_n passes through a 2-flop synchronizer.
- A synchronized low forces FAULT from any state: all bridge outputs 0, fault=1.
- FAULT exits to IDLE only when enable=0 and synchronized fault_n=1.
REQ-030 Without DC_BRIDGE_FAULT_EN, fault_n, fault, the synchronizer and the FAULT state are absent; the behaviour is otherwise identical.

Structure
REQ-031 Shared package dc_motor_pkg holds the state encoding, the DIR_FWD=1/DIR_REV=0 constants and the default DEAD_TIME_CYC.
REQ-032 Sub-module bridge_dead_timer contains the DEAD counter: start, done, parameter DEAD_TIME_CYC.
REQ-033 The top level contains the FSM and the registered output decode only.

Verification
REQ-034 Reset then enable=1, dir_req=1, DEAD_TIME_CYC=8 -> busy for 8 cycles, then in1=1, in2=0, and ena follows pwm_in with 1-cycle lag.
REQ-035 In RUN_FWD, dir_req 1->0 -> next cycle in1=in2=ena=0 for 8 cycles, then in1=0, in2=1; no cycle has both in1 and in2 high.
REQ-036 In RUN_REV, brake_req=1 -> in1=in2=ena=1 next cycle; release -> 8 dead cycles, then RUN_REV.
REQ-037 In DEAD at count 3, enable=0 -> IDLE next cycle; re-enable -> the full 8-cycle dead time restarts.
REQ-038 Assert rst=0 mid-RUN -> outputs 0 immediately (asynchronous); release -> IDLE.
REQ-039 With DC_BRIDGE_FAULT_EN, fault_n=0 in RUN -> FAULT after 3 cycles with outputs 0 and fault=1; exit requires enable=0 and fault_n=1.
